// File: rtl/seven_seg_display_scheduler.sv
// Arbitrates two 16-bit requesters onto the Basys 3 4-digit display: round-robin grant,
// sequential double-dabble conversion, minimum dwell, and time-multiplexed anode/cathode drive.
module seven_seg_display_scheduler #(
  parameter int REFRESH_BITS = 20,
  parameter int HOLD_CYCLES  = 100000000,
  parameter int HOLD_W       = 27
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_value,
  output logic [1:0]  req_ready,
  output logic [3:0]  anode_activate,
  output logic [6:0]  led_out,
  output logic        active_src,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

  state_t                  state, state_next;
  logic                    last_grant, grant, conv_src;
  logic                    transfer, conv_done, hold_done;
  logic [15:0]             bin;
  logic [19:0]             bcd, bcd_adj, bcd_shift;
  logic [3:0]              shift_cnt;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [15:0]             digits;
  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0]              sel;
  logic [3:0]              digit;

  always_comb begin
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  assign transfer  = (state == IDLE) && req_valid[grant];
  assign conv_done = (state == CONVERT) && (shift_cnt == 4'd15);
  assign hold_done = (state == HOLD) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (transfer) state_next = CONVERT;
      CONVERT: if (conv_done) state_next = (HOLD_CYCLES == 0) ? IDLE : HOLD;
      HOLD:    if (hold_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is masked during reset so an aborted cycle never shows a handshake.
  always_comb begin
    req_ready = '0;
    busy      = (state != IDLE);
    if (state == IDLE && !reset) req_ready[grant] = req_valid[grant];
  end

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[18:0], bin[15]};
  end

  // Display registers load only on the final shift so the old value stays up during conversion.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      conv_src   <= 1'b0;
      bin        <= '0;
      bcd        <= '0;
      shift_cnt  <= '0;
      hold_cnt   <= '0;
      digits     <= '0;
      overflow   <= 1'b0;
      active_src <= 1'b0;
    end else begin
      case (state)
        IDLE: if (transfer) begin
          bin        <= grant ? req_value[31:16] : req_value[15:0];
          last_grant <= grant;
          conv_src   <= grant;
          bcd        <= '0;
          shift_cnt  <= '0;
        end
        CONVERT: begin
          bcd       <= bcd_shift;
          bin       <= {bin[14:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
          if (conv_done) begin
            digits     <= bcd_shift[15:0];
            overflow   <= |bcd_shift[19:16];
            active_src <= conv_src;
            hold_cnt   <= '0;
          end
        end
        HOLD:    hold_cnt <= hold_cnt + HOLD_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) refresh <= '0;
    else       refresh <= refresh + REFRESH_BITS'(1);
  end

  assign sel = refresh[REFRESH_BITS-1 -: 2];

  always_comb begin
    case (sel)
      2'b00:   begin anode_activate = 4'b0111; digit = digits[15:12]; end
      2'b01:   begin anode_activate = 4'b1011; digit = digits[11:8];  end
      2'b10:   begin anode_activate = 4'b1101; digit = digits[7:4];   end
      default: begin anode_activate = 4'b1110; digit = digits[3:0];   end
    endcase
  end

  always_comb begin
    case (digit)
      4'd0:    led_out = 7'b0000001;
      4'd1:    led_out = 7'b1001111;
      4'd2:    led_out = 7'b0010010;
      4'd3:    led_out = 7'b0000110;
      4'd4:    led_out = 7'b1001100;
      4'd5:    led_out = 7'b0100100;
      4'd6:    led_out = 7'b0100000;
      4'd7:    led_out = 7'b0001111;
      4'd8:    led_out = 7'b0000000;
      4'd9:    led_out = 7'b0000100;
      default: led_out = 7'b0000001;
    endcase
  end

endmodule

// File: tb/tb_seven_seg_display_scheduler.sv
// Directed bench for seven_seg_display_scheduler: dwell build (HOLD_CYCLES=8) plus a
// no-dwell build (HOLD_CYCLES=0) sharing clock and reset.
module tb_seven_seg_display_scheduler;

  logic        clock_100Mhz = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [31:0] req_value = '0;
  logic [1:0]  req_ready;
  logic [3:0]  anode_activate;
  logic [6:0]  led_out;
  logic        active_src, overflow, busy;

  logic [1:0]  req_valid_h0 = '0;
  logic [31:0] req_value_h0 = '0;
  logic [1:0]  req_ready_h0;
  logic [3:0]  anode_activate_h0;
  logic [6:0]  led_out_h0;
  logic        active_src_h0, overflow_h0, busy_h0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock_100Mhz = ~clock_100Mhz;

  seven_seg_display_scheduler #(.REFRESH_BITS(4), .HOLD_CYCLES(8), .HOLD_W(4)) u_dut (
    .clock_100Mhz(clock_100Mhz), .reset(reset), .req_valid(req_valid), .req_value(req_value),
    .req_ready(req_ready), .anode_activate(anode_activate), .led_out(led_out),
    .active_src(active_src), .overflow(overflow), .busy(busy));

  seven_seg_display_scheduler #(.REFRESH_BITS(4), .HOLD_CYCLES(0), .HOLD_W(4)) u_dut_h0 (
    .clock_100Mhz(clock_100Mhz), .reset(reset), .req_valid(req_valid_h0), .req_value(req_value_h0),
    .req_ready(req_ready_h0), .anode_activate(anode_activate_h0), .led_out(led_out_h0),
    .active_src(active_src_h0), .overflow(overflow_h0), .busy(busy_h0));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock_100Mhz);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd1: return 7'b1001111;  4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;  4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;  4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;  4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;  default: return 7'b0000001;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [3:0] an, input logic [15:0] d);
    case (an)
      4'b0111: return seg_of(d[15:12]);
      4'b1011: return seg_of(d[11:8]);
      4'b1101: return seg_of(d[7:4]);
      4'b1110: return seg_of(d[3:0]);
      default: return 7'b1111111;
    endcase
  endfunction

  // One full refresh period (16 cycles at REFRESH_BITS=4) collects each digit's cathodes.
  task automatic scan_display(input string tag, input logic [15:0] d);
    logic [27:0] obs = '1;
    for (int i = 0; i < 16; i++) begin
      case (anode_activate)
        4'b0111: obs[27:21] = led_out;
        4'b1011: obs[20:14] = led_out;
        4'b1101: obs[13:7]  = led_out;
        4'b1110: obs[6:0]   = led_out;
        default: obs = '0;
      endcase
      tick();
    end
    check(tag, {4'h0, obs}, {4'h0, seg_of(d[15:12]), seg_of(d[11:8]), seg_of(d[7:4]), seg_of(d[3:0])});
  endtask

  // Returns one cycle after the transfer cycle (first CONVERT cycle).
  task automatic send(input int src, input logic [15:0] val);
    int n = 0;
    if (src == 0) req_value[15:0] = val; else req_value[31:16] = val;
    req_valid[src] = 1'b1;
    #1;
    while (!req_ready[src] && n < 200) begin tick(); n++; end
    check("accept", {30'd0, req_ready}, (src == 0) ? 32'd1 : 32'd2);
    tick();
    req_valid[src] = 1'b0;
    #1;
    check("ready_pulse", {30'd0, req_ready}, 32'd0);
  endtask

  logic [15:0] bv_val [4] = '{16'd9999, 16'd10000, 16'd65535, 16'd0};
  logic [15:0] bv_bcd [4] = '{16'h9999, 16'h0000, 16'h5535, 16'h0000};
  logic        bv_ov  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    // Reset state
    tick(); tick();
    check("rst_anode", {28'd0, anode_activate}, 32'b0111);
    check("rst_led", {25'd0, led_out}, 32'b0000001);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {30'd0, req_ready}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_src", {31'd0, active_src}, 32'd0);
    reset = 1'b0;
    tick();

    // Single request 1234 from requester 0
    send(0, 16'd1234);
    repeat (15) tick();
    check("t1_old_n16", {25'd0, led_out}, {25'd0, exp_seg(anode_activate, 16'h0000)});
    tick();
    check("t1_ovf", {31'd0, overflow}, 32'd0);
    check("t1_src", {31'd0, active_src}, 32'd0);
    scan_display("t1_disp", 16'h1234);

    // Requester 1 sends 500 while 1234 is shown: atomic switch at T+17
    send(1, 16'd500);
    for (int i = 1; i <= 16; i++) begin
      check("t4_hold_old", {25'd0, led_out}, {25'd0, exp_seg(anode_activate, 16'h1234)});
      check("t4_busy_conv", {31'd0, busy}, 32'd1);
      tick();
    end
    check("t4_new", {25'd0, led_out}, {25'd0, exp_seg(anode_activate, 16'h0500)});
    check("t4_src", {31'd0, active_src}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("t4_busy_hold", {31'd0, busy}, 32'd1);
      tick();
    end
    check("t4_idle", {31'd0, busy}, 32'd0);
    scan_display("t4_disp", 16'h0500);

    // Boundary values via requester 1
    for (int k = 0; k < 4; k++) begin
      send(1, bv_val[k]);
      repeat (16) tick();
      check("t2_ovf", {31'd0, overflow}, {31'd0, bv_ov[k]});
      check("t2_src", {31'd0, active_src}, 32'd1);
      scan_display("t2_disp", bv_bcd[k]);
    end

    // Both requesters continuously valid: alternate 0,1,0,1 every 25 cycles
    req_value = {16'd7, 16'd42};
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      gap = (k == 0) ? 0 : 17;
      while (req_ready == 2'b00 && gap < 60) begin tick(); gap++; end
      check("t3_grant", {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) check("t3_gap", gap, 32'd25);
      repeat (17) tick();
      check("t3_src", {31'd0, active_src}, k % 2);
      check("t3_disp", {25'd0, led_out},
            {25'd0, exp_seg(anode_activate, (k % 2 == 0) ? 16'h0042 : 16'h0007)});
    end
    req_valid = 2'b00;
    repeat (10) tick();

    // Reset 5 cycles into CONVERT aborts; afterwards tie goes to requester 0
    send(0, 16'd4321);
    repeat (4) tick();
    req_value = {16'd8765, 16'd2468};
    req_valid = 2'b11;
    reset = 1'b1;
    #1;
    check("t5_anode", {28'd0, anode_activate}, 32'b0111);
    check("t5_led", {25'd0, led_out}, 32'b0000001);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_ready", {30'd0, req_ready}, 32'd0);
    tick(); tick();
    check("t5_ready_hold", {30'd0, req_ready}, 32'd0);
    check("t5_src", {31'd0, active_src}, 32'd0);
    reset = 1'b0;
    #1;
    check("t5_tie", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    repeat (15) tick();
    check("t5_old_n16", {25'd0, led_out}, {25'd0, exp_seg(anode_activate, 16'h0000)});
    tick();
    check("t5_src_new", {31'd0, active_src}, 32'd0);
    scan_display("t5_disp", 16'h2468);

    // No-dwell build: requester 0 held valid is accepted every 17 cycles
    req_value_h0 = {16'd0, 16'd77};
    req_valid_h0 = 2'b01;
    #1;
    gap = 0;
    while (!req_ready_h0[0] && gap < 40) begin tick(); gap++; end
    check("t6_first", {30'd0, req_ready_h0}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      gap = 1;
      while (!req_ready_h0[0] && gap < 40) begin tick(); gap++; end
      check("t6_gap", gap, 32'd17);
    end
    req_valid_h0 = 2'b00;
    repeat (17) tick();
    check("t6_disp", {25'd0, led_out_h0}, {25'd0, exp_seg(anode_activate_h0, 16'h0077)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_display_scheduler.md
Name: seven_seg_display_scheduler

Overview:
Shares the 4-digit, 7-segment display on the Basys 3 board between two requesters.
- Each requester offers a 16-bit binary value over a valid/ready handshake.
- The block arbitrates round-robin and converts the granted value to BCD with a sequential double-dabble engine, one shift per cycle.
- It holds the result on the display for a minimum dwell time and drives the time-multiplexed anode and cathode lines itself.

Parameters:
- REFRESH_BITS, 20: width of the free-running refresh counter. Bits [REFRESH_BITS-1:REFRESH_BITS-2] select the digit.
- HOLD_CYCLES, 100000000: minimum number of clock_100Mhz cycles a new value stays displayed before the next grant. 0 means no dwell.
- HOLD_W, 27: width of the hold counter. Must satisfy 2^HOLD_W > HOLD_CYCLES.

Ports:
- clock_100Mhz, input, 1: system clock, 100 MHz.
- reset, input, 1: asynchronous, active-high reset.
- req_valid, input, 2: bit i means requester i offers a value.
- req_value, input, 32: requester 0 value on [15:0], requester 1 value on [31:16]; unsigned binary.
- req_ready, output, 2: bit i is high for exactly the cycle in which requester i's value is accepted.
- anode_activate, output, 4: digit enables, active low. Bit 3 is the leftmost digit.
- led_out, output, 7: segments a..g, active low, a is the MSB.
- active_src, output, 1: index of the requester whose value is currently displayed.
- overflow, output, 1: the displayed value is 10000 or more.
- busy, output, 1: high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous) forces:
  - state IDLE, req_ready 00, busy 0;
  - last_grant 1, so requester 0 wins the first tie;
  - all display digits 0, overflow 0, active_src 0;
  - refresh counter 0, giving anode_activate 0111 and led_out 0000001.
- FSM has three states: IDLE, CONVERT, HOLD.
- IDLE:
  - If exactly one req_valid bit is set, grant that requester.
  - If both are set, grant the requester that is not last_grant.
  - req_ready[g] is a combinational function of state==IDLE and the grant. The transfer cycle is any cycle where req_valid[g] and req_ready[g] are both high.
  - On transfer: capture req_value slice g, set last_grant to g, clear the 20-bit BCD scratch register, clear the shift count, and go to CONVERT.
- CONVERT:
  - Each cycle, every BCD nibble that is 5 or more gets +3.
  - Then {bcd, bin} shifts left one bit and shift_cnt increments.
  - After the 16th shift (shift_cnt reaches 15, so 16 cycles in CONVERT), do all of the following in one update: load the four display digits from bcd[15:0], set overflow to (bcd[19:16] != 0), set active_src to g.
  - Then go to HOLD, or to IDLE if HOLD_CYCLES = 0.
- Latency: for a transfer at cycle T, the new digits, overflow and active_src are visible from T+17. The next req_ready can occur no earlier than T+17+HOLD_CYCLES.
- HOLD: the hold counter counts HOLD_CYCLES cycles, then the FSM returns to IDLE. Requests are not accepted in HOLD.
- Display update is atomic: the digits never show a partially converted value. The old value stays visible through CONVERT.
- Values of 10000 or more show only the low four decimal digits, with overflow=1. Example: 65535 displays 5535.
- Requester rule: req_valid and req_value must stay stable until accepted. The block does not check this.
- Refresh:
  - The refresh counter is free-running, increments every cycle and wraps at 2^REFRESH_BITS. It is independent of the FSM.
  - Selector values 00, 01, 10 and 11 drive anode_activate 0111, 1011, 1101 and 1110, showing the thousands, hundreds, tens and units digit respectively.
- Cathode patterns (led_out) for digits 0 to 9:
  - 0: 0000001, 1: 1001111, 2: 0010010, 3: 0000110, 4: 1001100
  - 5: 0100100, 6: 0100000, 7: 0001111, 8: 0000000, 9: 0000100
  - Any other nibble value: 0000001.
- anode_activate and led_out are combinational from registers only, with no path from req_* inputs.
- Reset during CONVERT or HOLD aborts immediately: the display returns to 0 and no req_ready pulse is issued for the aborted cycle.
- Under sustained requests from both sides, grants strictly alternate 0,1,0,1.

Test Plan:
(Bench settings: REFRESH_BITS=4, HOLD_CYCLES=8.)
1. Requester 0 sends 1234 once → req_ready[0] pulses for 1 cycle; at T+17 the digits are 1,2,3,4 and overflow=0. Over one refresh period: anode 0111 with led_out 1001111, 1011/0010010, 1101/0000110, 1110/1001100.
2. Boundary values: 9999 → 9999 with overflow=0; 10000 → 0000 with overflow=1; 65535 → 5535 with overflow=1; 0 → 0000 with overflow=0.
3. Both requesters valid continuously, req0=42 and req1=7 → grants go 0,1,0,1. active_src toggles. Consecutive req_ready pulses are exactly 17+8=25 cycles apart. The display alternates between 0042 and 0007.
4. Requester 1 sends 500 while the display shows 1234 → the display stays 1234 for cycles T..T+16, then changes in a single cycle to 0500. busy is high from T+1 through the end of HOLD.
5. Assert reset 5 cycles into CONVERT → outputs immediately read digits 0000, anode 0111, led_out 0000001, busy 0. After release, a new request completes normally with 17-cycle latency and requester 0 wins a tie.
6. HOLD_CYCLES=0 build with requester 0 held valid → req_ready[0] pulses every 17 cycles and there are no idle gaps beyond one IDLE cycle.
